// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes symbolic instruction requests (kind + register/immediate fields)
//   into 16-bit instruction words. It streams those words into instruction
//   memory at consecutive addresses, starting at a base address sampled on
//   start. A small FIFO decouples request acceptance from memory back-pressure.
//
//   Optional feature macro: IMM_RANGE_CHECK_EN
//     defined   : I-type immediates that do not fit a signed 6-bit field set
//                 the sticky err_range flag. The word is still written with
//                 imm[5:0].
//     undefined : the immediate is silently truncated and err_range is tied 0.

module instr_encoder_loader #(
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [2:0]    req_ra,
  input  logic [2:0]    req_rb,
  input  logic [2:0]    req_rd,
  input  logic [11:0]   req_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  input  logic          imem_ready,
  output logic          err_illegal,
  output logic          err_range
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Session control state
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NW-1:0] count_q, count_d;
  logic [NW-1:0] accepted_q, accepted_d;
  logic [NW-1:0] written_q, written_d;
  logic          err_illegal_q, err_illegal_d;
  logic          done_q, done_d;
  logic          imem_we_q, imem_we_d;

  // Encoded-word FIFO
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [15:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Datapath handshakes
  logic [15:0] enc_word;
  logic        enc_legal;
  logic        fifo_full;
  logic        fifo_empty;
  logic        hs;
  logic        push;
  logic        pop;

  // Encoder: map the symbolic request onto the 16-bit instruction format.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req_kind)
      4'd0, 4'd1, 4'd2, 4'd3: enc_word = {4'h0, req_ra, req_rb, req_rd, req_kind[2:0]};
      4'd4:                   enc_word = {4'd4,  req_ra, req_rb, req_imm[5:0]};
      4'd5:                   enc_word = {4'd11, req_ra, req_rb, req_imm[5:0]};
      4'd6:                   enc_word = {4'd15, req_ra, req_rb, req_imm[5:0]};
      4'd7:                   enc_word = {4'd8,  req_ra, req_rb, req_imm[5:0]};
      4'd8:                   enc_word = {4'd2,  req_imm};
      default:                enc_legal = 1'b0;
    endcase
  end

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign req_ready  = (state_q == ST_LOAD) && !fifo_full && (accepted_q < count_q);
  assign hs         = req_valid && req_ready;
  assign push       = hs && enc_legal;
  assign pop        = imem_we_q && imem_ready;

  // FIFO next state: push at the tail, pop at the head, track occupancy.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    // The write strobe follows occupancy one cycle later.
    imem_we_d = (fifo_cnt_d != '0);
  end

  // FIFO registers; storage is reset so imem_wdata reads 0 out of reset.
  // NOTE: this memory is small and drives an output port directly, so it is
  // reset; a large RAM would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      imem_we_q  <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      imem_we_q  <= imem_we_d;
    end
  end

  // Session FSM next state: counters, address walk and sticky illegal flag.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    accepted_d    = accepted_q;
    written_d     = written_q;
    err_illegal_d = err_illegal_q;
    done_d        = (state_q == ST_DONE);

    // A completed memory write advances the address and the written count.
    if (pop) begin
      addr_d    = addr_q + AW'(1);
      written_d = written_q + NW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = base_addr;
          count_d       = count;
          accepted_d    = '0;
          written_d     = '0;
          err_illegal_d = 1'b0;
          state_d       = (count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (push) begin
          accepted_d = accepted_q + NW'(1);
        end
        if (hs && !enc_legal) begin
          err_illegal_d = 1'b1;
        end
        if (accepted_q == count_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && (written_q == count_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Session FSM registers; reset aborts any session in progress.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples
  // values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      accepted_q    <= '0;
      written_q     <= '0;
      err_illegal_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      accepted_q    <= accepted_d;
      written_q     <= written_d;
      err_illegal_q <= err_illegal_d;
      done_q        <= done_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_range_q, err_range_d;
  logic imm_itype;
  logic imm_bad;

  assign imm_itype = (req_kind >= 4'd4) && (req_kind <= 4'd7);
  assign imm_bad   = !((&req_imm[11:5]) || !(|req_imm[11:5]));

  // Range flag next state: cleared by start, set by an out-of-range I-type.
  always_comb begin
    err_range_d = err_range_q;
    if ((state_q == ST_IDLE) && start) begin
      err_range_d = 1'b0;
    end else if (hs && imm_itype && imm_bad) begin
      err_range_d = 1'b1;
    end
  end

  // Range flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_range_q <= 1'b0;
    end else begin
      err_range_q <= err_range_d;
    end
  end

  assign err_range = err_range_q;
`else
  assign err_range = 1'b0;
`endif

  assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done        = done_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = fifo_q[rd_ptr_q];
  assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: a table of encoding vectors streamed
// through one session, plus directed sequences for back-pressure, address
// wrap, illegal kinds, empty sessions, immediate range and mid-session reset.

module tb_instr_encoder_loader;

  localparam int AW = 8;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic EXP_RANGE = 1'b1;
`else
  localparam logic EXP_RANGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_kind = '0;
  logic [2:0]    req_ra = '0;
  logic [2:0]    req_rb = '0;
  logic [2:0]    req_rd = '0;
  logic [11:0]   req_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          imem_ready = 1'b1;
  logic          err_illegal;
  logic          err_range;

  instr_encoder_loader #(.AW(AW), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_ra      (req_ra),
    .req_rb      (req_rb),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .imem_ready  (imem_ready),
    .err_illegal (err_illegal),
    .err_range   (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [11:0] imm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  int checks    = 0;
  int failures  = 0;
  int we_cycles = 0;
  int we_snap   = 0;
  logic [AW-1:0] got_addr [$];
  logic [15:0]   got_data [$];

  // Memory-side monitor: records every completed write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) we_cycles++;
    if (imem_we && imem_ready) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_session(input logic [AW-1:0] b, input logic [AW:0] c);
    @(posedge clk); #1;
    got_addr.delete();
    got_data.delete();
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input logic [3:0] k, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] d, input logic [11:0] im);
    bit ok;
    ok        = 1'b0;
    req_kind  = k;
    req_ra    = a;
    req_rb    = b;
    req_rd    = d;
    req_imm   = im;
    req_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_vec(input int i);
    send(vecs[i].kind, vecs[i].ra, vecs[i].rb, vecs[i].rd, vecs[i].imm);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    //          kind   ra    rb    rd    imm       expected word
    vecs[0]  = '{4'd0, 3'd1, 3'd2, 3'd3, 12'h000, 16'h0298}; // ADD
    vecs[1]  = '{4'd4, 3'd1, 3'd4, 3'd0, 12'h005, 16'h4305}; // ADDI
    vecs[2]  = '{4'd8, 3'd0, 3'd0, 3'd0, 12'h123, 16'h2123}; // JMP
    vecs[3]  = '{4'd1, 3'd7, 3'd0, 3'd5, 12'h000, 16'h0E29}; // SUB
    vecs[4]  = '{4'd2, 3'd2, 3'd5, 3'd6, 12'h000, 16'h0572}; // AND
    vecs[5]  = '{4'd3, 3'd4, 3'd4, 3'd7, 12'h000, 16'h093B}; // OR
    vecs[6]  = '{4'd5, 3'd3, 3'd6, 3'd0, 12'h01F, 16'hB79F}; // LW
    vecs[7]  = '{4'd6, 3'd0, 3'd1, 3'd0, 12'hFE0, 16'hF060}; // SW  imm -32
    vecs[8]  = '{4'd7, 3'd5, 3'd3, 3'd0, 12'hFFF, 16'h8AFF}; // BEQ imm -1
    vecs[9]  = '{4'd8, 3'd0, 3'd0, 3'd0, 12'hFFF, 16'h2FFF}; // JMP all ones
    vecs[10] = '{4'd4, 3'd6, 3'd7, 3'd0, 12'h000, 16'h4DC0}; // ADDI imm 0

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_req_ready",   32'(req_ready),   32'd0);
    check("rst_imem_we",     32'(imem_we),     32'd0);
    check("rst_imem_addr",   32'(imem_addr),   32'd0);
    check("rst_imem_wdata",  32'(imem_wdata),  32'd0);
    check("rst_err_illegal", 32'(err_illegal), 32'd0);
    check("rst_err_range",   32'(err_range),   32'd0);
    rst = 1'b0;

    // Table session: every kind, consecutive addresses from 0x10
    start_session(8'h10, 9'd11);
    check("tbl_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 11; i++) send_vec(i);
    wait_done("tbl_done");
    check("tbl_busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    check("tbl_done_pulse", 32'(done), 32'd0);
    check("tbl_n_writes", 32'(got_data.size()), 32'd11);
    for (int i = 0; i < 11 && i < got_data.size(); i++) begin
      logic [AW-1:0] ea;
      ea = 8'h10 + AW'(i);
      check($sformatf("tbl_addr[%0d]", i), 32'(got_addr[i]), 32'(ea));
      check($sformatf("tbl_data[%0d]", i), 32'(got_data[i]), 32'(vecs[i].exp));
    end

    // Back-pressure: memory stalled, FIFO fills after 4 accepts
    @(posedge clk); #1;
    imem_ready = 1'b0;
    start_session(8'h40, 9'd6);
    for (int i = 0; i < 4; i++) send_vec(i);
    req_kind  = vecs[4].kind;
    req_ra    = vecs[4].ra;
    req_rb    = vecs[4].rb;
    req_rd    = vecs[4].rd;
    req_imm   = vecs[4].imm;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready),  32'd0);
      check("stall_we",        32'(imem_we),    32'd1);
      check("stall_addr",      32'(imem_addr),  32'h40);
      check("stall_wdata",     32'(imem_wdata), 32'(vecs[0].exp));
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send_vec(4);
    send_vec(5);
    wait_done("stall_done");
    check("stall_n_writes", 32'(got_data.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      logic [AW-1:0] ea;
      ea = 8'h40 + AW'(i);
      check($sformatf("stall_addr[%0d]", i), 32'(got_addr[i]), 32'(ea));
      check($sformatf("stall_data[%0d]", i), 32'(got_data[i]), 32'(vecs[i].exp));
    end

    // Address wrap: 0xFE, 0xFF, 0x00
    start_session(8'hFE, 9'd3);
    for (int i = 0; i < 3; i++) send(4'd5, 3'd1, 3'd2, 3'd0, 12'(i));
    wait_done("wrap_done");
    check("wrap_n_writes", 32'(got_data.size()), 32'd3);
    if (got_data.size() == 3) begin
      check("wrap_addr0", 32'(got_addr[0]), 32'hFE);
      check("wrap_addr1", 32'(got_addr[1]), 32'hFF);
      check("wrap_addr2", 32'(got_addr[2]), 32'h00);
      check("wrap_data0", 32'(got_data[0]), 32'hB280);
      check("wrap_data1", 32'(got_data[1]), 32'hB281);
      check("wrap_data2", 32'(got_data[2]), 32'hB282);
    end

    // Illegal kind mid-stream: flagged, not written, not counted
    start_session(8'h20, 9'd2);
    send_vec(0);
    send(4'd12, 3'd1, 3'd1, 3'd1, 12'h000);
    check("ill_flag", 32'(err_illegal), 32'd1);
    send_vec(3);
    wait_done("ill_done");
    check("ill_n_writes", 32'(got_data.size()), 32'd2);
    if (got_data.size() == 2) begin
      check("ill_addr1", 32'(got_addr[1]), 32'h21);
      check("ill_data0", 32'(got_data[0]), 32'(vecs[0].exp));
      check("ill_data1", 32'(got_data[1]), 32'(vecs[3].exp));
    end
    check("ill_sticky", 32'(err_illegal), 32'd1);

    // Empty session: done two cycles after start, no writes, errors cleared
    we_snap = we_cycles;
    start_session(8'h55, 9'd0);
    check("zero_err_cleared", 32'(err_illegal), 32'd0);
    @(negedge clk);
    check("zero_done_c1", 32'(done), 32'd0);
    check("zero_busy",    32'(busy), 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(done), 32'd1);
    @(negedge clk);
    check("zero_done_c3", 32'(done), 32'd0);
    check("zero_no_we", 32'(we_cycles), 32'(we_snap));

    // Immediate range: ADDI imm=0x040 truncates to 0
    start_session(8'h30, 9'd1);
    send(4'd4, 3'd0, 3'd0, 3'd0, 12'h040);
    wait_done("range_done");
    check("range_n_writes", 32'(got_data.size()), 32'd1);
    if (got_data.size() == 1) check("range_data", 32'(got_data[0]), 32'h4000);
    check("range_flag", 32'(err_range), 32'(EXP_RANGE));

    // Reset mid-session with two words buffered
    @(posedge clk); #1;
    imem_ready = 1'b0;
    start_session(8'h80, 9'd4);
    send(4'd9, 3'd0, 3'd0, 3'd0, 12'h000);
    send_vec(1);
    send_vec(2);
    check("mrst_pre_we",  32'(imem_we),     32'd1);
    check("mrst_pre_err", 32'(err_illegal), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_we",        32'(imem_we),     32'd0);
    check("mrst_busy",      32'(busy),        32'd0);
    check("mrst_req_ready", 32'(req_ready),   32'd0);
    check("mrst_err_ill",   32'(err_illegal), 32'd0);
    check("mrst_err_range", 32'(err_range),   32'd0);
    check("mrst_addr",      32'(imem_addr),   32'd0);
    we_snap = we_cycles;
    @(posedge clk); #1;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("mrst_no_we",     32'(we_cycles),        32'(we_snap));
    check("mrst_no_writes", 32'(got_data.size()),  32'd0);
    check("mrst_idle_busy", 32'(busy),             32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
